// File: rtl/cmd_parser_if.sv
// Byte-in / operand-out channel bundle for cmd_parser.
// The slave modport is the parser's view. The master modport is the surrounding UART and ALU side.
interface cmd_parser_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  opcode_o;
  logic        start_o;
  logic [32:0] operand_o;
  logic        operand_valid_o;
  logic        operand_ready_i;
  logic        operand_first_o;
  logic        operand_last_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output rx_data_i, rx_valid_i, operand_ready_i,
    input  rx_ready_o, opcode_o, start_o, operand_o, operand_valid_o,
           operand_first_o, operand_last_o, done_o, err_o
  );

  modport slave (
    input  rx_data_i, rx_valid_i, operand_ready_i,
    output rx_ready_o, opcode_o, start_o, operand_o, operand_valid_o,
           operand_first_o, operand_last_o, done_o, err_o
  );
endinterface

// File: rtl/cmd_parser.sv
// Command packet parser. It validates a 4-byte header (opcode, reserved, length LSB, length MSB)
// and emits the payload as operands over a valid/ready handshake.
module cmd_parser #(
  parameter logic [15:0] MAX_LEN = 16'd1024
) (
  input logic         clk,
  input logic         rst,
  cmd_parser_if.slave bus
);
  typedef enum logic [2:0] {OPC, RSVD, LEN_LO, LEN_HI, PAYLOAD, EMIT, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, len_lo_q;
  logic [15:0] cnt_q, hdr_len, pay_len;
  logic [32:0] operand_q;
  logic [1:0]  byte_idx_q;
  logic        first_pend_q, valid_q, first_q, last_q, start_q, done_q, err_q;
  logic        rx_ready, rx_fire, op_fire, rule_ok, hdr_ok, word_done, cnt_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= OPC;
    else     state_q <= state_d;
  end

  always_comb begin
    rx_ready  = (state_q != EMIT);
    rx_fire   = rx_ready && bus.rx_valid_i;
    op_fire   = valid_q && bus.operand_ready_i;
    hdr_len   = {bus.rx_data_i, len_lo_q};
    pay_len   = hdr_len - 16'd4;
    cnt_last  = (cnt_q == 16'd1);
    word_done = (opcode_q == 8'hEC) || (byte_idx_q == 2'd3) || cnt_last;
    rule_ok   = 1'b0;
    case (opcode_q)
      8'hEC:        rule_ok = (pay_len >= 16'd1);
      8'hAD, 8'hAC: rule_ok = (pay_len >= 16'd4) && (pay_len[1:0] == 2'b00);
      8'hD1:        rule_ok = (pay_len == 16'd8);
      default:      rule_ok = 1'b1;
    endcase
    // A length below 4 wraps pay_len, so the lower bound must gate the opcode rules.
    hdr_ok  = (hdr_len >= 16'd4) && (hdr_len <= MAX_LEN) && rule_ok;
    state_d = state_q;
    case (state_q)
      OPC:     if (rx_fire) state_d = RSVD;
      RSVD:    if (rx_fire) state_d = LEN_LO;
      LEN_LO:  if (rx_fire) state_d = LEN_HI;
      LEN_HI: begin
        if (rx_fire) begin
          if (hdr_ok)                state_d = (pay_len == '0) ? OPC : PAYLOAD;
          else if (hdr_len > 16'd4)  state_d = DRAIN;
          else                       state_d = OPC;
        end
      end
      PAYLOAD: if (rx_fire && word_done) state_d = EMIT;
      EMIT:    if (op_fire) state_d = last_q ? OPC : PAYLOAD;
      DRAIN:   if (rx_fire && cnt_last) state_d = OPC;
      default: state_d = OPC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q     <= '0;
      len_lo_q     <= '0;
      cnt_q        <= '0;
      operand_q    <= '0;
      byte_idx_q   <= '0;
      first_pend_q <= 1'b0;
      valid_q      <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        OPC:    if (rx_fire) opcode_q <= bus.rx_data_i;
        LEN_LO: if (rx_fire) len_lo_q <= bus.rx_data_i;
        LEN_HI: begin
          if (rx_fire) begin
            if (hdr_ok) begin
              start_q      <= 1'b1;
              cnt_q        <= pay_len;
              first_pend_q <= 1'b1;
              byte_idx_q   <= '0;
            end else begin
              err_q <= 1'b1;
              cnt_q <= (hdr_len > 16'd4) ? pay_len : '0;
            end
          end
        end
        PAYLOAD: begin
          if (rx_fire) begin
            cnt_q <= (cnt_q != '0) ? cnt_q - 16'd1 : cnt_q;
            // The first byte of a word clears the stale upper bytes of the previous word.
            if (byte_idx_q == 2'd0) operand_q <= {25'd0, bus.rx_data_i};
            else                    operand_q[{byte_idx_q, 3'b000} +: 8] <= bus.rx_data_i;
            byte_idx_q <= word_done ? 2'd0 : byte_idx_q + 2'd1;
            if (word_done) begin
              valid_q      <= 1'b1;
              first_q      <= first_pend_q;
              last_q       <= cnt_last;
              first_pend_q <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (op_fire) begin
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= last_q;
          end
        end
        DRAIN: if (rx_fire) cnt_q <= (cnt_q != '0) ? cnt_q - 16'd1 : cnt_q;
        default: ;
      endcase
    end
  end

  assign bus.rx_ready_o      = rx_ready;
  assign bus.opcode_o        = opcode_q;
  assign bus.start_o         = start_q;
  assign bus.operand_o       = operand_q;
  assign bus.operand_valid_o = valid_q;
  assign bus.operand_first_o = first_q;
  assign bus.operand_last_o  = last_q;
  assign bus.done_o          = done_q;
  assign bus.err_o           = err_q;
endmodule

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001: Parameter MAX_LEN, default 16'd1024; largest legal total packet length in bytes, header included.
REQ-002: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003: rst  input  1  reset, asynchronous and active-high.
REQ-004: rx_data_i  input  8  byte from UART receiver.
REQ-005: rx_valid_i  input  1  rx_data_i valid.
REQ-006: rx_ready_o  output  1  parser accepts rx_data_i this cycle; byte transfers when rx_valid_i && rx_ready_o.
REQ-007: opcode_o  output  8  opcode of current packet, held from header acceptance until the next packet's opcode byte.
REQ-008: start_o  output  1  one-cycle pulse, valid header accepted; drives ALU state_start_i.
REQ-009: operand_o  output  33  packed operand, bit 32 always 0; drives ALU data inputs.
REQ-010: operand_valid_o  output  1  operand_o valid.
REQ-011: operand_ready_i  input  1  consumer accepts operand; transfer when valid && ready.
REQ-012: operand_first_o / operand_last_o  output  1 each  marks first / last operand of packet; valid with operand_valid_o.
REQ-013: done_o  output  1  one-cycle pulse after last operand transfer.
REQ-014: err_o  output  1  one-cycle pulse on malformed header.

Function
REQ-015: Packet = opcode byte, reserved byte (ignored), length LSB, length MSB, payload; length counts all bytes including the 4-byte header.
REQ-016: States: OPC, RSVD, LEN_LO, LEN_HI, PAYLOAD, EMIT, DRAIN. Each header state advances on one byte transfer.
REQ-017: rx_ready_o = 1 in OPC, RSVD, LEN_LO, LEN_HI, PAYLOAD, DRAIN; 0 in EMIT.
REQ-018: Header check at LEN_HI transfer, using P = length-4:
- 0xEC: P >= 1.
- 0xAD, 0xAC: P >= 4 and P % 4 == 0.
- 0xD1: P == 8.
- Any opcode: length <= MAX_LEN.
REQ-019: Valid header -> start_o pulses the cycle after the LEN_HI transfer; go to PAYLOAD.
REQ-020: Invalid header -> err_o pulses the cycle after the LEN_HI transfer, no start_o. If length > 4, go to DRAIN and discard length-4 bytes, else go to OPC.
REQ-021: Arithmetic opcodes pack 4 payload bytes little-endian: first byte -> operand_o[7:0], fourth -> [31:24].
REQ-022: 0xEC emits one operand per payload byte: operand_o = {25'b0, byte}.
REQ-023: After the word-completing byte transfer, go to EMIT; operand_valid_o rises the next cycle (1-cycle latency).
REQ-024: In EMIT, operand_o, operand_first_o and operand_last_o are held stable until handshake. operand_valid_o stays high until handshake.
REQ-025: After an operand transfer: if it is the last operand, pulse done_o the next cycle and go to OPC; otherwise go to PAYLOAD.
REQ-026: operand_first_o = 1 only for the packet's first operand; operand_last_o = 1 only for its last. Both may be 1 together (single operand).
REQ-027: A 16-bit remaining-byte counter loads P at LEN_HI and decrements on each payload or drain transfer. Last operand/drain byte is detected at counter == 1; the counter never wraps below 0.
REQ-028: rx_valid_i low in any state stalls that state with no side effects; no timeout.
REQ-029: start_o, done_o and err_o are mutually exclusive in any cycle.

Reset
REQ-030: On rst assertion, asynchronously and regardless of state (including mid-packet or mid-EMIT):
- state = OPC;
- opcode_o = 8'h00; operand_o = 0; remaining-byte counter = 0;
- operand_valid_o, operand_first_o, operand_last_o, start_o, done_o, err_o = 0.
REQ-031: rx_ready_o = 1 in the first cycle after rst deasserts. Partial packets are discarded, never resumed.

Verification
REQ-032: Bytes AD 00 0C 00 01 00 00 00 02 00 00 00, operand_ready_i=1 -> start_o once; operands 0x00000001 (first) and 0x00000002 (last); done_o once.
REQ-033: Bytes EC 00 06 00 41 42 -> operands 0x041 (first), 0x042 (last); done_o once.
REQ-034: Bytes D1 00 08 00 + 4 bytes (P=4) -> err_o once, no start_o; 4 payload bytes drained; following AD 00 08 00 05 00 00 00 -> operand 0x5 with first=last=1.
REQ-035: operand_ready_i held 0 for 5 cycles during an AD packet -> operand_valid_o stays 1 with stable data; rx_ready_o=0 throughout; no byte lost.
REQ-036: rst pulsed after the 2nd payload byte of an AC packet -> all outputs reset; next full AC 00 08 00 03 00 00 00 yields operand 0x3 correctly.
REQ-037: Length 0x0500 with MAX_LEN=1024, and length 0x0003 -> err_o each; parser returns to OPC (length 3 without drain).
